// File: rtl/tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_pkg
// Description : Shared UART definitions used by both the transmitter and the
//               receiver. It holds the one-hot state encodings, the
//               oversampling ratio and the frame bit layout. The layout is
//               1 start bit, N data bits sent LSB first, 1 parity bit and
//               1 stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_pkg;

  // One-hot state encodings; RX and TX use the same values.
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } tx_state_t;

  // s_ticks per bit.
  localparam int COUNT_TICKS = 16;

  // Frame layout, as bit positions within one frame of the default 8-bit word.
  localparam int FRAME_BITS_DATA     = 8;
  localparam int FRAME_BIT_START     = 0;
  localparam int FRAME_BIT_LAST_DATA = FRAME_BITS_DATA;
  localparam int FRAME_BIT_PARITY    = FRAME_BITS_DATA + 1;
  localparam int FRAME_BIT_STOP      = FRAME_BITS_DATA + 2;

  // Number of s_ticks in a complete frame with n_bits_data data bits.
  function automatic int frame_ticks(input int n_bits_data);
    return (n_bits_data + 3) * COUNT_TICKS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_if
// Description : Parallel-side handshake of the UART transmitter.
//   tx_start     : request strobe, master -> transmitter
//   data_i       : word to send, master -> transmitter
//   tx_data      : serial line, transmitter -> master
//   tx_busy      : frame in progress, transmitter -> master
//   tx_done_tick : one-clock frame-complete pulse, transmitter -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface tx_if #(
  parameter int N_BITS_DATA = 8
);
  logic                   tx_start;
  logic [N_BITS_DATA-1:0] data_i;
  logic                   tx_data;
  logic                   tx_busy;
  logic                   tx_done_tick;

  modport master (
    output tx_start,
    output data_i,
    input  tx_data,
    input  tx_busy,
    input  tx_done_tick
  );

  modport slave (
    input  tx_start,
    input  data_i,
    output tx_data,
    output tx_busy,
    output tx_done_tick
  );
endinterface
`default_nettype wire

// File: rtl/tx.sv
`default_nettype none
// ============================================================================
// Module      : tx
// Description : UART serial transmitter that uses the shared 16x oversampling
//               tick. It sends a start bit, N_BITS_DATA data bits (LSB
//               first), a parity bit and a stop bit, and pulses
//               tx_done_tick when the stop bit ends.
// Ports       :
//   clock    in  : the only clock; all logic is on its rising edge
//   reset    in  : synchronous, active-low reset
//   s_ticks  in  : one-clock oversampling tick, 16 per bit
//   bus      slave tx_if : tx_start / data_i in, tx_data / tx_busy /
//                          tx_done_tick out (all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module tx
  import tx_pkg::*;
#(
  parameter int N_BITS_DATA  = 8,
  parameter int N_CONT_TICKS = 4,
  parameter int N_BITS_STATE = 5,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic s_ticks,
  tx_if.slave       bus
);

  // Parameter sanity: the state register is the package enum, and both
  // counters must be able to hold their terminal values.
  if (N_BITS_STATE != $bits(tx_state_t)) begin : g_chk_state_width
    $error("tx: N_BITS_STATE must equal the width of tx_state_t");
  end
  if ((COUNT_TICKS > (1 << N_CONT_TICKS)) || (N_BITS_DATA > (1 << N_CONT_TICKS))
      || (N_BITS_DATA < 2)) begin : g_chk_counter_width
    $error("tx: N_CONT_TICKS too small for COUNT_TICKS or N_BITS_DATA");
  end

  localparam logic [N_CONT_TICKS-1:0] C_TICK_LAST = N_CONT_TICKS'(COUNT_TICKS - 1);
  localparam logic [N_CONT_TICKS-1:0] C_BIT_LAST  = N_CONT_TICKS'(N_BITS_DATA - 1);

  tx_state_t               r_state;
  logic [N_BITS_DATA-1:0]  r_shift;
  logic [N_CONT_TICKS-1:0] r_tick_cnt;
  logic [N_CONT_TICKS-1:0] r_bit_cnt;
  logic                    r_parity;
  logic                    r_tx_data;
  logic                    r_tx_busy;
  logic                    r_tx_done;

  logic                    w_bit_end;
  logic [N_BITS_DATA-1:0]  w_shift_next;

  // The last tick of a bit: the tick counter wraps and the FSM advances.
  assign w_bit_end    = s_ticks && (r_tick_cnt == C_TICK_LAST);
  assign w_shift_next = r_shift >> 1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_parity   <= 1'b0;
      r_tx_data  <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;

      // The tick counter runs in every state except Idle. Idle clears it
      // when it accepts a request, so each bit lasts exactly 16 ticks from
      // the moment its state is entered.
      if ((r_state != ST_IDLE) && s_ticks) begin
        r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_tx_data <= 1'b1;
          r_tx_busy <= 1'b0;
          if (bus.tx_start) begin
            r_shift    <= bus.data_i;
            r_parity   <= (^bus.data_i) ^ PARITY_ODD;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx_data  <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_state    <= ST_START;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            r_tx_data <= r_shift[0];
            r_state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == C_BIT_LAST) begin
              r_tx_data <= r_parity;
              r_state   <= ST_PARITY;
            end else begin
              // tx_data is registered, so the next bit is loaded from
              // the value the shift register is about to take.
              r_tx_data <= w_shift_next[0];
            end
          end
        end

        ST_PARITY: begin
          if (w_bit_end) begin
            r_tx_data <= 1'b1;
            r_state   <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (w_bit_end) begin
            r_tx_data <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          // Recover from any corrupted encoding with the line idle high.
          r_tx_data <= 1'b1;
          r_tx_busy <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data      = r_tx_data;
  assign bus.tx_busy      = r_tx_busy;
  assign bus.tx_done_tick = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx
// Description : Self-checking bench for the UART transmitter. It drives two
//               instances, one with even parity and one with odd parity,
//               from the same stimulus. s_ticks is driven once every 4
//               clocks, so one bit is 64 clocks. The serial lines are
//               recorded, then checked against hand-computed levels and
//               decoded by a mid-bit sampling receiver model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx;

  localparam int MAX_REC = 4096;

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic s_ticks = 1'b0;

  tx_if #(.N_BITS_DATA(8)) bus_e ();
  tx_if #(.N_BITS_DATA(8)) bus_o ();

  tx #(.N_BITS_DATA(8), .N_CONT_TICKS(4), .N_BITS_STATE(5), .PARITY_ODD(1'b0)) dut_e (
    .clock   (clock),
    .reset   (reset),
    .s_ticks (s_ticks),
    .bus     (bus_e)
  );

  tx #(.N_BITS_DATA(8), .N_CONT_TICKS(4), .N_BITS_STATE(5), .PARITY_ODD(1'b1)) dut_o (
    .clock   (clock),
    .reset   (reset),
    .s_ticks (s_ticks),
    .bus     (bus_o)
  );

  always #5 clock = ~clock;

  int n_checks   = 0;
  int n_fail     = 0;
  int tick_phase = 0;
  int stall_left = 0;

  // rec_*[c] holds the outputs seen after clock edge c of a run.
  // rec_tick[c] holds the s_ticks value applied at edge c+1.
  logic rec_e    [MAX_REC];
  logic rec_o    [MAX_REC];
  logic rec_done [MAX_REC];
  logic rec_busy [MAX_REC];
  logic rec_tick [MAX_REC];
  int   rec_len = 0;

  logic [7:0] q_data [$];
  logic [7:0] q_rx   [$];

  // Line levels for 0x55 with even parity: start, D0..D7 (LSB first), parity, stop.
  logic exp55 [0:10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic start, input logic [7:0] d);
    bus_e.tx_start = start;
    bus_e.data_i   = d;
    bus_o.tx_start = start;
    bus_o.data_i   = d;
  endtask

  // Advance to the next falling edge and set s_ticks for the coming rising edge.
  task automatic cyc();
    @(negedge clock);
    if (stall_left > 0) begin
      s_ticks = 1'b0;
      stall_left--;
    end else begin
      s_ticks = (tick_phase == 3);
    end
    tick_phase = (tick_phase + 1) % 4;
  endtask

  function automatic logic rec_get(input int sel, input int idx);
    case (sel)
      0:       return rec_e[idx];
      1:       return rec_o[idx];
      2:       return rec_done[idx];
      3:       return rec_busy[idx];
      default: return rec_tick[idx];
    endcase
  endfunction

  function automatic int count_eq(input int sel, input int start, input int len, input logic val);
    int n;
    n = 0;
    for (int i = start; i < start + len; i++) begin
      if (rec_get(sel, i) === val) n++;
    end
    return n;
  endfunction

  function automatic int first_done();
    for (int i = 0; i < rec_len; i++) begin
      if (rec_done[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  // Run n_cyc clocks. The first request is aligned so that its accepting edge
  // carries a tick, which makes the start bit exactly 64 clocks long. Later
  // requests are issued in the cycle where tx_done_tick is high.
  task automatic run(input int n_cyc, input int strobe_at, input int stall_at, input int rst_at);
    int fi;
    int guard;
    fi    = 0;
    guard = 0;
    reset = 1'b1;
    while (s_ticks !== 1'b1 && guard < 8) begin
      cyc();
      guard++;
    end
    drive(1'b1, q_data[0]);
    fi = 1;
    for (int c = 0; c < n_cyc; c++) begin
      cyc();
      rec_e[c]    = bus_e.tx_data;
      rec_o[c]    = bus_o.tx_data;
      rec_done[c] = bus_e.tx_done_tick;
      rec_busy[c] = bus_e.tx_busy;
      rec_tick[c] = s_ticks;
      drive(1'b0, 8'hEE);
      reset = (c == rst_at) ? 1'b0 : 1'b1;
      if (c == stall_at) stall_left = 200;
      if (c == strobe_at) drive(1'b1, 8'h12);
      if (bus_e.tx_done_tick === 1'b1 && fi < q_data.size()) begin
        drive(1'b1, q_data[fi]);
        fi++;
      end
    end
    rec_len = n_cyc;
    drive(1'b0, 8'h00);
    reset = 1'b1;
  endtask

  // Receiver model: find each falling edge, sample at mid-bit, and check the
  // start, parity and stop levels. Decoded bytes go to q_rx.
  task automatic decode(input int sel, input logic odd, output int bad);
    int         i;
    logic       prv;
    logic [7:0] b;
    bad = 0;
    i   = 0;
    q_rx.delete();
    while (i < rec_len) begin
      prv = (i == 0) ? 1'b1 : rec_get(sel, i - 1);
      if (prv === 1'b1 && rec_get(sel, i) === 1'b0) begin
        if (i + 32 + 640 >= rec_len) begin
          bad++;
          break;
        end
        if (rec_get(sel, i + 32) !== 1'b0) bad++;
        for (int j = 0; j < 8; j++) b[j] = rec_get(sel, i + 32 + 64 * (j + 1));
        if (rec_get(sel, i + 32 + 64 * 9) !== ((^b) ^ odd)) bad++;
        if (rec_get(sel, i + 32 + 640) !== 1'b1) bad++;
        q_rx.push_back(b);
        i = i + 32 + 640;
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    int bad;

    drive(1'b0, 8'h00);
    reset = 1'b0;
    repeat (3) cyc();
    check_eq("reset tx_data", int'(bus_e.tx_data), 1);
    check_eq("reset tx_busy", int'(bus_e.tx_busy), 0);
    check_eq("reset tx_done_tick", int'(bus_e.tx_done_tick), 0);
    reset = 1'b1;
    repeat (4) cyc();

    // 0x55: each level lasts 64 clocks; done 704 clocks after start bit begins.
    q_data = '{8'h55};
    run(720, -1, -1, -1);
    for (int b = 0; b < 11; b++) begin
      check_eq($sformatf("0x55 bit%0d level", b), count_eq(0, 64 * b, 64, exp55[b]), 64);
    end
    check_eq("0x55 done index", first_done(), 704);
    check_eq("0x55 done count", count_eq(2, 0, 720, 1'b1), 1);
    check_eq("0x55 busy before done", int'(rec_busy[703]), 1);
    check_eq("0x55 busy at done", int'(rec_busy[704]), 0);
    check_eq("0x55 line at done", int'(rec_e[704]), 1);
    check_eq("0x55 odd parity bit", count_eq(1, 576, 64, 1'b1), 64);

    // Parity = XOR of data bits XOR PARITY_ODD.
    q_data = '{8'h00};
    run(720, -1, -1, -1);
    check_eq("0x00 even parity=0", count_eq(0, 576, 64, 1'b0), 64);
    check_eq("0x00 odd parity=1", count_eq(1, 576, 64, 1'b1), 64);
    q_data = '{8'hFF};
    run(720, -1, -1, -1);
    check_eq("0xFF even parity=0", count_eq(0, 576, 64, 1'b0), 64);
    check_eq("0xFF odd parity=1", count_eq(1, 576, 64, 1'b1), 64);
    check_eq("0xFF data bits high", count_eq(0, 64, 512, 1'b1), 512);

    // Back-to-back loopback: A3, 00, FF.
    q_data = '{8'hA3, 8'h00, 8'hFF};
    run(2300, -1, -1, -1);
    decode(0, 1'b0, bad);
    check_eq("loopback frame count", q_rx.size(), 3);
    if (q_rx.size() == 3) begin
      check_eq("loopback byte0", int'(q_rx[0]), 'hA3);
      check_eq("loopback byte1", int'(q_rx[1]), 'h00);
      check_eq("loopback byte2", int'(q_rx[2]), 'hFF);
    end
    check_eq("loopback frame errors", bad, 0);
    check_eq("loopback done count", count_eq(2, 0, 2300, 1'b1), 3);
    decode(1, 1'b1, bad);
    check_eq("loopback odd frame count", q_rx.size(), 3);
    check_eq("loopback odd frame errors", bad, 0);

    // Strobe with 0x12 during the data bits of a 0x34 frame is lost.
    q_data = '{8'h34};
    run(800, 64 * 3 + 5, -1, -1);
    decode(0, 1'b0, bad);
    check_eq("busy strobe frame count", q_rx.size(), 1);
    if (q_rx.size() == 1) check_eq("busy strobe byte", int'(q_rx[0]), 'h34);
    check_eq("busy strobe frame errors", bad, 0);
    check_eq("busy strobe done count", count_eq(2, 0, 800, 1'b1), 1);

    // Reset pulse during data bit 3 (frame bit 4: clocks 256..319).
    q_data = '{8'hC3};
    run(800, -1, -1, 266);
    check_eq("mid reset busy before", int'(rec_busy[266]), 1);
    check_eq("mid reset line after", int'(rec_e[267]), 1);
    check_eq("mid reset busy after", int'(rec_busy[267]), 0);
    check_eq("mid reset no done", count_eq(2, 0, 800, 1'b1), 0);
    check_eq("mid reset line stays high", count_eq(0, 267, 533, 1'b1), 533);
    q_data = '{8'h5A};
    run(800, -1, -1, -1);
    decode(0, 1'b0, bad);
    check_eq("after reset frame count", q_rx.size(), 1);
    if (q_rx.size() == 1) check_eq("after reset byte", int'(q_rx[0]), 'h5A);
    check_eq("after reset frame errors", bad, 0);
    check_eq("after reset done index", first_done(), 704);

    // 200-clock tick stall inside the parity bit of 0x0F (parity 0).
    // The parity bit spans 64 + 200 clocks and still sees exactly 16 ticks.
    q_data = '{8'h0F};
    run(1000, -1, 596, -1);
    check_eq("stall parity holds low", count_eq(0, 576, 264, 1'b0), 264);
    check_eq("stall stop begins", int'(rec_e[840]), 1);
    check_eq("stall parity tick total", count_eq(4, 576, 264, 1'b1), 16);
    check_eq("stall done index", first_done(), 904);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
